// File: rtl/data_memory.sv
// 64 x 32-bit block memory behind the data cache; ACCESS_CYCLES edges from acceptance to completion, then one DONE cycle.
// busywait is combinational: high for a pending single request in IDLE and throughout ACCESS, low in DONE.
module data_memory #(
    parameter int ACCESS_CYCLES = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [5:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [7:0] CNT_LOAD = 8'(ACCESS_CYCLES - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic [5:0]  addr_q;
    logic [31:0] wdata_q;
    logic        op_write;
    logic [31:0] mem [64];
    logic        req_one;

    // Both request lines high is an illegal request and is never accepted.
    assign req_one  = read ^ write;
    assign busywait = (state == ACCESS) || ((state == IDLE) && req_one);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            readdata <= 32'h0;
            addr_q   <= 6'd0;
            wdata_q  <= 32'h0;
            op_write <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                mem[i] <= 32'h0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_one) begin
                        addr_q   <= address;
                        wdata_q  <= writedata;
                        op_write <= write;
                        cnt      <= CNT_LOAD;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        if (op_write) begin
                            mem[addr_q] <= wdata_q;
                        end else begin
                            readdata <= mem[addr_q];
                        end
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
